// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, execute, optional memory access, writeback.
// Commits each instruction exactly once by gating the GPR write and PC update to the WB state.
module cpu_seq_ctrl #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_data,
  input  logic        ifu_rsp_err,
  output logic [31:0] inst,
  input  logic        dec_is_load,
  input  logic        dec_is_store,
  input  logic        dec_is_ebreak,
  input  logic        dec_illegal,
  output logic        lsu_req_valid,
  output logic        lsu_req_wen,
  input  logic        lsu_req_ready,
  input  logic        lsu_rsp_valid,
  input  logic        lsu_rsp_err,
  output logic        gpr_wen_en,
  output logic        pc_wen,
  output logic        halt,
  output logic [2:0]  halt_cause,
  output logic [2:0]  state,
  output logic [31:0] retire_cnt
);

  localparam int unsigned CNT_W = 32;
  localparam logic [CNT_W-1:0] TIMEOUT_W = CNT_W'(TIMEOUT);

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_ILLEGAL = 3'd2;
  localparam logic [2:0] CAUSE_FETCH   = 3'd3;
  localparam logic [2:0] CAUSE_MEM     = 3'd4;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_FETCH_REQ  = 3'd1,
    S_FETCH_WAIT = 3'd2,
    S_EXEC       = 3'd3,
    S_MEM_REQ    = 3'd4,
    S_MEM_WAIT   = 3'd5,
    S_WB         = 3'd6,
    S_HALT       = 3'd7
  } state_e;

  state_e           state_q;
  logic [31:0]      inst_q;
  logic [31:0]      retire_cnt_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [2:0]       halt_cause_q;
  logic             store_q;
  logic             timeout_hit;

  // Fires on the wait cycle in which the counter would reach TIMEOUT; a response that cycle wins.
  assign timeout_hit = (TIMEOUT != 0) && ((wait_cnt_q + CNT_W'(1)) == TIMEOUT_W);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      inst_q       <= NOP_INST;
      retire_cnt_q <= '0;
      wait_cnt_q   <= '0;
      halt_cause_q <= CAUSE_NONE;
      store_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_FETCH_REQ;
        S_FETCH_REQ: begin
          if (ifu_req_ready) begin
            state_q    <= S_FETCH_WAIT;
            wait_cnt_q <= '0;
          end
        end
        S_FETCH_WAIT: begin
          if (ifu_rsp_valid) begin
            if (ifu_rsp_err) begin
              state_q      <= S_HALT;
              halt_cause_q <= CAUSE_FETCH;
            end else begin
              inst_q  <= ifu_rsp_data;
              state_q <= S_EXEC;
            end
          end else if (timeout_hit) begin
            state_q      <= S_HALT;
            halt_cause_q <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        S_EXEC: begin
          if (dec_illegal) begin
            state_q      <= S_HALT;
            halt_cause_q <= CAUSE_ILLEGAL;
          end else if (dec_is_ebreak) begin
            state_q      <= S_HALT;
            halt_cause_q <= CAUSE_EBREAK;
            retire_cnt_q <= retire_cnt_q + 32'd1;
          end else if (dec_is_load || dec_is_store) begin
            store_q <= dec_is_store;
            state_q <= S_MEM_REQ;
          end else begin
            store_q <= 1'b0;
            state_q <= S_WB;
          end
        end
        S_MEM_REQ: begin
          if (lsu_req_ready) begin
            state_q    <= S_MEM_WAIT;
            wait_cnt_q <= '0;
          end
        end
        S_MEM_WAIT: begin
          if (lsu_rsp_valid) begin
            if (lsu_rsp_err) begin
              state_q      <= S_HALT;
              halt_cause_q <= CAUSE_MEM;
            end else begin
              state_q <= S_WB;
            end
          end else if (timeout_hit) begin
            state_q      <= S_HALT;
            halt_cause_q <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
        end
        S_WB: begin
          retire_cnt_q <= retire_cnt_q + 32'd1;
          state_q      <= S_FETCH_REQ;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Moore outputs decoded from the state register only.
  assign ifu_req_valid = (state_q == S_FETCH_REQ);
  assign lsu_req_valid = (state_q == S_MEM_REQ);
  assign lsu_req_wen   = store_q;
  assign gpr_wen_en    = (state_q == S_WB) && !store_q;
  assign pc_wen        = (state_q == S_WB);
  assign halt          = (state_q == S_HALT);
  assign halt_cause    = halt_cause_q;
  assign state         = state_q;
  assign inst          = inst_q;
  assign retire_cnt    = retire_cnt_q;

endmodule
